// File: rtl/wb_forward_unit.sv
// rtl/wb_forward_unit.sv - writeback consumer: pending scoreboard, writeback history, operand forwarding and stall
// Optional macro WBFWD_STATS_EN adds the StallCycles_OUT / FwdHits_OUT counters.
module wb_forward_unit #(
    parameter int HIST_DEPTH = 4,
    parameter int CNT_W      = 2
) (
    input  logic        CLOCK,
    input  logic        RESET,
    input  logic        IssueValid_IN,
    input  logic [4:0]  IssueDest_IN,
    output logic        IssueReady_OUT,
    input  logic        write_IN,
    input  logic [4:0]  WBRegister_IN,
    input  logic [31:0] WBRegisterValue_IN,
    input  logic [4:0]  ReadRegister1_IN,
    input  logic [4:0]  ReadRegister2_IN,
    input  logic [31:0] RegData1_IN,
    input  logic [31:0] RegData2_IN,
    output logic [31:0] Operand1_OUT,
    output logic [31:0] Operand2_OUT,
    output logic        Stall_OUT,
    output logic        ErrUnderflow_OUT
`ifdef WBFWD_STATS_EN
    ,
    output logic [31:0] StallCycles_OUT,
    output logic [31:0] FwdHits_OUT
`endif
);

    localparam int PTR_W = $clog2(HIST_DEPTH);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [CNT_W-1:0]      pending_q [32];
    logic [CNT_W-1:0]      pending_d [32];
    logic [HIST_DEPTH-1:0] hist_vld_q, hist_vld_d;
    logic [4:0]            hist_reg_q [HIST_DEPTH];
    logic [31:0]           hist_val_q [HIST_DEPTH];
    logic [PTR_W-1:0]      head_q, head_d;
    logic                  err_q, err_d;

    logic                  issue_acc;
    logic                  wb_eff;
    logic [4:0]            src     [2];
    logic [31:0]           rf_data [2];
    logic [31:0]           operand [2];
    logic [1:0]            fwd_hit;
    logic [1:0]            src_stall;

    assign src[0]     = ReadRegister1_IN;
    assign src[1]     = ReadRegister2_IN;
    assign rf_data[0] = RegData1_IN;
    assign rf_data[1] = RegData2_IN;

    assign IssueReady_OUT   = (IssueDest_IN == 5'd0) || (pending_q[IssueDest_IN] != CNT_MAX);
    assign issue_acc        = IssueValid_IN && IssueReady_OUT && (IssueDest_IN != 5'd0);
    assign wb_eff           = write_IN && (WBRegister_IN != 5'd0);
    assign Operand1_OUT     = operand[0];
    assign Operand2_OUT     = operand[1];
    assign Stall_OUT        = |src_stall;
    assign ErrUnderflow_OUT = err_q;

    // Same-register issue and retire in one cycle cancel out.
    always_comb begin
        for (int r = 0; r < 32; r++) begin
            pending_d[r] = pending_q[r];
            if (issue_acc && (IssueDest_IN == 5'(r))) begin
                if (!(wb_eff && (WBRegister_IN == 5'(r)) && (pending_q[r] != '0)))
                    pending_d[r] = pending_q[r] + CNT_ONE;
            end else if (wb_eff && (WBRegister_IN == 5'(r)) && (pending_q[r] != '0)) begin
                pending_d[r] = pending_q[r] - CNT_ONE;
            end
        end
        err_d = err_q || (wb_eff && (pending_q[WBRegister_IN] == '0));
    end

    // Issue invalidates stale copies before the new writeback is stored.
    always_comb begin
        hist_vld_d = hist_vld_q;
        if (issue_acc) begin
            for (int k = 0; k < HIST_DEPTH; k++) begin
                if (hist_reg_q[k] == IssueDest_IN)
                    hist_vld_d[k] = 1'b0;
            end
        end
        if (wb_eff)
            hist_vld_d[head_q] = 1'b1;
        head_d = head_q + PTR_W'(wb_eff);
    end

    // Scan oldest to newest so the newest matching entry wins.
    always_comb begin
        logic             hhit;
        logic [31:0]      hval;
        logic             wmatch;
        logic [PTR_W-1:0] idx;
        for (int n = 0; n < 2; n++) begin
            hhit = 1'b0;
            hval = '0;
            idx  = '0;
            for (int k = 0; k < HIST_DEPTH; k++) begin
                idx = head_q + PTR_W'(k);
                if (hist_vld_q[idx] && (hist_reg_q[idx] == src[n])) begin
                    hhit = 1'b1;
                    hval = hist_val_q[idx];
                end
            end
            wmatch = write_IN && (WBRegister_IN == src[n]);
            if (src[n] == 5'd0)  operand[n] = '0;
            else if (wmatch)     operand[n] = WBRegisterValue_IN;
            else if (hhit)       operand[n] = hval;
            else                 operand[n] = rf_data[n];
            fwd_hit[n]   = (src[n] != 5'd0) && (wmatch || hhit);
            src_stall[n] = (src[n] != 5'd0) && (pending_q[src[n]] != '0)
                           && !(wmatch && (pending_q[src[n]] == CNT_ONE));
        end
    end

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            for (int r = 0; r < 32; r++)
                pending_q[r] <= '0;
            for (int k = 0; k < HIST_DEPTH; k++) begin
                hist_reg_q[k] <= '0;
                hist_val_q[k] <= '0;
            end
            hist_vld_q <= '0;
            head_q     <= '0;
            err_q      <= 1'b0;
        end else begin
            for (int r = 0; r < 32; r++)
                pending_q[r] <= pending_d[r];
            if (wb_eff) begin
                hist_reg_q[head_q] <= WBRegister_IN;
                hist_val_q[head_q] <= WBRegisterValue_IN;
            end
            hist_vld_q <= hist_vld_d;
            head_q     <= head_d;
            err_q      <= err_d;
        end
    end

`ifdef WBFWD_STATS_EN
    logic [31:0] stall_cnt_q, fwd_cnt_q;

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            stall_cnt_q <= '0;
            fwd_cnt_q   <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_q + 32'(Stall_OUT);
            fwd_cnt_q   <= fwd_cnt_q + 32'(|fwd_hit);
        end
    end

    assign StallCycles_OUT = stall_cnt_q;
    assign FwdHits_OUT     = fwd_cnt_q;
`else
    logic unused_fwd_hit;
    assign unused_fwd_hit = |fwd_hit;
`endif

endmodule

// File: tb/tb_wb_forward_unit.sv
// tb/tb_wb_forward_unit.sv - directed self-checking bench for wb_forward_unit
module tb_wb_forward_unit;

    logic        CLOCK = 1'b0;
    logic        RESET;
    logic        IssueValid_IN;
    logic [4:0]  IssueDest_IN;
    logic        IssueReady_OUT;
    logic        write_IN;
    logic [4:0]  WBRegister_IN;
    logic [31:0] WBRegisterValue_IN;
    logic [4:0]  ReadRegister1_IN, ReadRegister2_IN;
    logic [31:0] RegData1_IN, RegData2_IN;
    logic [31:0] Operand1_OUT, Operand2_OUT;
    logic        Stall_OUT;
    logic        ErrUnderflow_OUT;
`ifdef WBFWD_STATS_EN
    logic [31:0] StallCycles_OUT, FwdHits_OUT;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    always #5 CLOCK = ~CLOCK;

    wb_forward_unit #(.HIST_DEPTH(4), .CNT_W(2)) dut (
        .CLOCK              (CLOCK),
        .RESET              (RESET),
        .IssueValid_IN      (IssueValid_IN),
        .IssueDest_IN       (IssueDest_IN),
        .IssueReady_OUT     (IssueReady_OUT),
        .write_IN           (write_IN),
        .WBRegister_IN      (WBRegister_IN),
        .WBRegisterValue_IN (WBRegisterValue_IN),
        .ReadRegister1_IN   (ReadRegister1_IN),
        .ReadRegister2_IN   (ReadRegister2_IN),
        .RegData1_IN        (RegData1_IN),
        .RegData2_IN        (RegData2_IN),
        .Operand1_OUT       (Operand1_OUT),
        .Operand2_OUT       (Operand2_OUT),
        .Stall_OUT          (Stall_OUT),
        .ErrUnderflow_OUT   (ErrUnderflow_OUT)
`ifdef WBFWD_STATS_EN
        ,
        .StallCycles_OUT    (StallCycles_OUT),
        .FwdHits_OUT        (FwdHits_OUT)
`endif
    );

    task automatic tick();
        @(posedge CLOCK);
        #1;
        IssueValid_IN = 1'b0;
        write_IN      = 1'b0;
    endtask

    task automatic test_reset();
        RESET = 1'b1;
        IssueValid_IN = 0; IssueDest_IN = 0; write_IN = 0; WBRegister_IN = 0; WBRegisterValue_IN = 0;
        ReadRegister1_IN = 5'd7; ReadRegister2_IN = 5'd0;
        RegData1_IN = 32'h1234; RegData2_IN = 32'hFFFF_FFFF;
        #3;
        n_cmp++; if (Stall_OUT !== 1'b0) begin n_bad++; $display("FAIL rst_stall: got %b want 0", Stall_OUT); end
        n_cmp++; if (IssueReady_OUT !== 1'b1) begin n_bad++; $display("FAIL rst_ready: got %b want 1", IssueReady_OUT); end
        n_cmp++; if (ErrUnderflow_OUT !== 1'b0) begin n_bad++; $display("FAIL rst_err: got %b want 0", ErrUnderflow_OUT); end
        n_cmp++; if (Operand1_OUT !== 32'h1234) begin n_bad++; $display("FAIL rst_op1: got %h want 00001234", Operand1_OUT); end
        n_cmp++; if (Operand2_OUT !== 32'h0) begin n_bad++; $display("FAIL rst_op2_r0: got %h want 0", Operand2_OUT); end
        @(negedge CLOCK);
        RESET = 1'b0;
        // underflow on r10, then two issues to r5
        tick(); write_IN = 1; WBRegister_IN = 5'd10; WBRegisterValue_IN = 32'h5;
        tick(); IssueValid_IN = 1; IssueDest_IN = 5'd5;
        tick(); IssueValid_IN = 1; IssueDest_IN = 5'd5;
        tick(); ReadRegister1_IN = 5'd5;
        #1;
        n_cmp++; if (Stall_OUT !== 1'b1) begin n_bad++; $display("FAIL pre_rst_stall: got %b want 1", Stall_OUT); end
        n_cmp++; if (ErrUnderflow_OUT !== 1'b1) begin n_bad++; $display("FAIL pre_rst_err: got %b want 1", ErrUnderflow_OUT); end
        RESET = 1'b1;
        #1;
        n_cmp++; if (Stall_OUT !== 1'b0) begin n_bad++; $display("FAIL mid_rst_stall: got %b want 0", Stall_OUT); end
        n_cmp++; if (ErrUnderflow_OUT !== 1'b0) begin n_bad++; $display("FAIL mid_rst_err: got %b want 0", ErrUnderflow_OUT); end
        #1;
        RESET = 1'b0;
        RegData1_IN = 32'hAAAA;
        #1;
        n_cmp++; if (Operand1_OUT !== 32'hAAAA) begin n_bad++; $display("FAIL post_rst_op1: got %h want 0000aaaa", Operand1_OUT); end
        n_cmp++; if (Stall_OUT !== 1'b0) begin n_bad++; $display("FAIL post_rst_stall: got %b want 0", Stall_OUT); end
    endtask

    task automatic test_bypass();
        tick(); IssueValid_IN = 1; IssueDest_IN = 5'd8;
        tick(); ReadRegister1_IN = 5'd8; RegData1_IN = 32'h0;
        #1;
        n_cmp++; if (Stall_OUT !== 1'b1) begin n_bad++; $display("FAIL byp_stall: got %b want 1", Stall_OUT); end
        tick(); write_IN = 1; WBRegister_IN = 5'd8; WBRegisterValue_IN = 32'hDEADBEEF;
        #1;
        n_cmp++; if (Operand1_OUT !== 32'hDEADBEEF) begin n_bad++; $display("FAIL byp_op1: got %h want deadbeef", Operand1_OUT); end
        n_cmp++; if (Stall_OUT !== 1'b0) begin n_bad++; $display("FAIL byp_stall_clr: got %b want 0", Stall_OUT); end
        tick();
        #1;
        n_cmp++; if (Operand1_OUT !== 32'hDEADBEEF) begin n_bad++; $display("FAIL byp_hist_op1: got %h want deadbeef", Operand1_OUT); end
        n_cmp++; if (Stall_OUT !== 1'b0) begin n_bad++; $display("FAIL byp_after_stall: got %b want 0", Stall_OUT); end
    endtask

    task automatic test_saturate();
        logic [1:0] exp_stall;
        for (int i = 0; i < 3; i++) begin
            tick(); IssueValid_IN = 1; IssueDest_IN = 5'd3;
            #1;
            n_cmp++; if (IssueReady_OUT !== 1'b1) begin n_bad++; $display("FAIL sat_ready%0d: got %b want 1", i, IssueReady_OUT); end
        end
        tick(); IssueValid_IN = 1; IssueDest_IN = 5'd3;
        #1;
        n_cmp++; if (IssueReady_OUT !== 1'b0) begin n_bad++; $display("FAIL sat_ready_full: got %b want 0", IssueReady_OUT); end
        tick(); ReadRegister1_IN = 5'd3;
        #1;
        n_cmp++; if (Stall_OUT !== 1'b1) begin n_bad++; $display("FAIL sat_stall: got %b want 1", Stall_OUT); end
        for (int i = 0; i < 3; i++) begin
            tick(); write_IN = 1; WBRegister_IN = 5'd3; WBRegisterValue_IN = 32'h30 + 32'(i);
            exp_stall = (i < 2) ? 2'd1 : 2'd0;
            #1;
            n_cmp++; if (Stall_OUT !== exp_stall[0]) begin n_bad++; $display("FAIL sat_wb_stall%0d: got %b want %b", i, Stall_OUT, exp_stall[0]); end
        end
        tick(); IssueDest_IN = 5'd3;
        #1;
        n_cmp++; if (Stall_OUT !== 1'b0) begin n_bad++; $display("FAIL sat_end_stall: got %b want 0", Stall_OUT); end
        n_cmp++; if (ErrUnderflow_OUT !== 1'b0) begin n_bad++; $display("FAIL sat_end_err: got %b want 0", ErrUnderflow_OUT); end
        n_cmp++; if (IssueReady_OUT !== 1'b1) begin n_bad++; $display("FAIL sat_end_ready: got %b want 1", IssueReady_OUT); end
        n_cmp++; if (Operand1_OUT !== 32'h32) begin n_bad++; $display("FAIL sat_end_op1: got %h want 00000032", Operand1_OUT); end
    endtask

    task automatic test_underflow();
        tick(); write_IN = 1; WBRegister_IN = 5'd9; WBRegisterValue_IN = 32'h11;
        #1;
        n_cmp++; if (ErrUnderflow_OUT !== 1'b0) begin n_bad++; $display("FAIL uf_err_early: got %b want 0", ErrUnderflow_OUT); end
        tick();
        #1;
        n_cmp++; if (ErrUnderflow_OUT !== 1'b1) begin n_bad++; $display("FAIL uf_err_set: got %b want 1", ErrUnderflow_OUT); end
        tick(); tick();
        ReadRegister2_IN = 5'd9; RegData2_IN = 32'h0;
        #1;
        n_cmp++; if (Operand2_OUT !== 32'h11) begin n_bad++; $display("FAIL uf_op2: got %h want 00000011", Operand2_OUT); end
        n_cmp++; if (ErrUnderflow_OUT !== 1'b1) begin n_bad++; $display("FAIL uf_err_sticky: got %b want 1", ErrUnderflow_OUT); end
        ReadRegister2_IN = 5'd0;
    endtask

    task automatic test_same_cycle();
        tick(); IssueValid_IN = 1; IssueDest_IN = 5'd4;
        tick(); IssueValid_IN = 1; IssueDest_IN = 5'd4;
        write_IN = 1; WBRegister_IN = 5'd4; WBRegisterValue_IN = 32'h22;
        tick(); ReadRegister1_IN = 5'd4; RegData1_IN = 32'h99;
        #1;
        n_cmp++; if (Stall_OUT !== 1'b1) begin n_bad++; $display("FAIL sc_stall: got %b want 1", Stall_OUT); end
        n_cmp++; if (Operand1_OUT !== 32'h22) begin n_bad++; $display("FAIL sc_hist_op1: got %h want 00000022", Operand1_OUT); end
        tick(); write_IN = 1; WBRegister_IN = 5'd4; WBRegisterValue_IN = 32'h23;
        #1;
        n_cmp++; if (Stall_OUT !== 1'b0) begin n_bad++; $display("FAIL sc_retire_stall: got %b want 0", Stall_OUT); end
        tick();
        #1;
        n_cmp++; if (Stall_OUT !== 1'b0) begin n_bad++; $display("FAIL sc_after_stall: got %b want 0", Stall_OUT); end
    endtask

    task automatic test_r0();
        tick(); IssueValid_IN = 1; IssueDest_IN = 5'd0;
        write_IN = 1; WBRegister_IN = 5'd0; WBRegisterValue_IN = 32'h5;
        ReadRegister1_IN = 5'd0; RegData1_IN = 32'hFFFF;
        #1;
        n_cmp++; if (Operand1_OUT !== 32'h0) begin n_bad++; $display("FAIL r0_op1: got %h want 0", Operand1_OUT); end
        tick();
        #1;
        n_cmp++; if (Stall_OUT !== 1'b0) begin n_bad++; $display("FAIL r0_stall: got %b want 0", Stall_OUT); end
        n_cmp++; if (Operand1_OUT !== 32'h0) begin n_bad++; $display("FAIL r0_op1_after: got %h want 0", Operand1_OUT); end
    endtask

    task automatic test_history_wrap();
        logic [31:0] exp;
        for (int r = 1; r <= 5; r++) begin
            tick(); write_IN = 1; WBRegister_IN = 5'(r); WBRegisterValue_IN = 32'h100 + 32'(r);
        end
        tick(); RegData1_IN = 32'hCAFE; RegData2_IN = 32'hBEEF;
        for (int r = 1; r <= 5; r++) begin
            ReadRegister1_IN = 5'(r);
            ReadRegister2_IN = 5'(6 - r);
            #1;
            exp = (r == 1) ? 32'hCAFE : 32'h100 + 32'(r);
            n_cmp++; if (Operand1_OUT !== exp) begin n_bad++; $display("FAIL hist_op1_r%0d: got %h want %h", r, Operand1_OUT, exp); end
            exp = (r == 5) ? 32'hBEEF : 32'h100 + 32'(6 - r);
            n_cmp++; if (Operand2_OUT !== exp) begin n_bad++; $display("FAIL hist_op2_r%0d: got %h want %h", 6 - r, Operand2_OUT, exp); end
            n_cmp++; if (Stall_OUT !== 1'b0) begin n_bad++; $display("FAIL hist_stall_r%0d: got %b want 0", r, Stall_OUT); end
        end
    endtask

    initial begin
        test_reset();
        test_bypass();
        test_saturate();
        test_underflow();
        test_same_cycle();
        test_r0();
        test_history_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
